// File: rtl/matmul_sequencer_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
// Holds FSM states, opcodes and control-window word offsets.
package matmul_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_t;

    localparam int unsigned OP_NOP    = 0;
    localparam int unsigned OP_MATMUL = 1;

    localparam logic [2:0] CW_OP  = 3'd0;
    localparam logic [2:0] CW_W_A = 3'd1;
    localparam logic [2:0] CW_H_A = 3'd2;
    localparam logic [2:0] CW_W_B = 3'd3;
    localparam logic [2:0] CW_H_B = 3'd4;
    localparam logic [2:0] CW_GO  = 3'd5;

    function automatic bit dim_bad(
        input int d,
        input int max_dim
    );
        return (d == 0) || (d > max_dim);
    endfunction

endpackage

// File: rtl/matmul_sequencer_mac.sv
// Signed multiply-accumulate for one C element.
// Products and sums wrap modulo 2^DATA_W; first beat loads.
module matmul_mac #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              first,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc
);

    logic signed [DATA_W-1:0] w_prod;
    logic signed [DATA_W-1:0] r_acc;

    assign w_prod = $signed(a) * $signed(b);
    assign acc    = r_acc;

    // reset is active-low, matching the bus reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (valid) begin
            r_acc <= first ? w_prod : r_acc + w_prod;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Walks the C = A x B index space, issuing operand reads
// and writing each accumulated C element to result memory.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DIM_W    = 5,
    parameter int MAX_DIM  = 16,
    parameter int ADDR_W   = 9,
    parameter int C_ADDR_W = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [DATA_W-1:0]   cfg_op,
    input  logic [DIM_W-1:0]    cfg_w_a,
    input  logic [DIM_W-1:0]    cfg_h_a,
    input  logic [DIM_W-1:0]    cfg_w_b,
    input  logic [DIM_W-1:0]    cfg_h_b,
    input  logic                go,
    output logic [ADDR_W-1:0]   rda_addr,
    output logic [ADDR_W-1:0]   rdb_addr,
    output logic                rd_en,
    input  logic [DATA_W-1:0]   rda_data,
    input  logic [DATA_W-1:0]   rdb_data,
    output logic                c_we,
    output logic [C_ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0]   c_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0]   r_op;
    logic [DIM_W-1:0]    r_w_a;
    logic [DIM_W-1:0]    r_h_a;
    logic [DIM_W-1:0]    r_w_b;
    logic [DIM_W-1:0]    r_h_b;
    logic [DIM_W-1:0]    r_i;
    logic [DIM_W-1:0]    r_j;
    logic [DIM_W-1:0]    r_k;
    logic [ADDR_W-1:0]   r_a_base;
    logic [ADDR_W-1:0]   r_a_addr;
    logic [ADDR_W-1:0]   r_b_base;
    logic [ADDR_W-1:0]   r_b_addr;
    logic [C_ADDR_W-1:0] r_c_addr;
    logic                r_err;
    logic                r_vld;
    logic                r_first;

    logic                w_cfg_err;
    logic                w_k_last;
    logic                w_j_last;
    logic                w_i_last;
    logic [ADDR_W-1:0]   w_k_w;
    logic [ADDR_W-1:0]   w_n_w;
    logic [ADDR_W-1:0]   w_mk;
    logic [DATA_W-1:0]   w_acc;

    assign w_cfg_err = (r_op != DATA_W'(OP_MATMUL))
                     || dim_bad(int'(r_w_a), MAX_DIM)
                     || dim_bad(int'(r_h_a), MAX_DIM)
                     || dim_bad(int'(r_w_b), MAX_DIM)
                     || dim_bad(int'(r_h_b), MAX_DIM)
                     || (r_w_a != r_h_b);

    assign w_k_last = (r_k == r_w_a - DIM_W'(1));
    assign w_j_last = (r_j == r_w_b - DIM_W'(1));
    assign w_i_last = (r_i == r_h_a - DIM_W'(1));

    assign w_k_w = ADDR_W'(r_w_a);
    assign w_n_w = ADDR_W'(r_w_b);
    assign w_mk  = ADDR_W'(r_h_a) * ADDR_W'(r_w_a);

    assign rda_addr = r_a_addr;
    assign rdb_addr = r_b_addr;
    assign c_addr   = r_c_addr;
    assign c_data   = w_acc;
    assign err      = r_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (go) w_next = S_CHECK;
            S_CHECK: w_next = w_cfg_err ? S_IDLE : S_RUN;
            S_RUN:   if (w_k_last) w_next = S_DRAIN;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: begin
                if (w_i_last && w_j_last) w_next = S_FIN;
                else                      w_next = S_RUN;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_en = 1'b0;
        c_we  = 1'b0;
        unique case (r_state)
            S_IDLE:  ;
            S_CHECK: busy = 1'b1;
            S_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_WRITE: begin
                busy = 1'b1;
                c_we = 1'b1;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    // Addresses advance incrementally: A by 1 per k, B by N per k
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_op     <= '0;
            r_w_a    <= '0;
            r_h_a    <= '0;
            r_w_b    <= '0;
            r_h_b    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_a_base <= '0;
            r_a_addr <= '0;
            r_b_base <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_op  <= cfg_op;
                        r_w_a <= cfg_w_a;
                        r_h_a <= cfg_h_a;
                        r_w_b <= cfg_w_b;
                        r_h_b <= cfg_h_b;
                        r_err <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_cfg_err) begin
                        r_err <= 1'b1;
                    end else begin
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_a_base <= '0;
                        r_a_addr <= '0;
                        r_b_base <= w_mk;
                        r_b_addr <= w_mk;
                        r_c_addr <= '0;
                    end
                end
                S_RUN: begin
                    r_k      <= r_k + DIM_W'(1);
                    r_a_addr <= r_a_addr + ADDR_W'(1);
                    r_b_addr <= r_b_addr + w_n_w;
                end
                S_WRITE: begin
                    r_k      <= '0;
                    r_c_addr <= r_c_addr + C_ADDR_W'(1);
                    if (w_j_last) begin
                        r_j      <= '0;
                        r_i      <= r_i + DIM_W'(1);
                        r_a_base <= r_a_base + w_k_w;
                        r_a_addr <= r_a_base + w_k_w;
                        r_b_addr <= r_b_base;
                    end else begin
                        r_j      <= r_j + DIM_W'(1);
                        r_a_addr <= r_a_base;
                        r_b_addr <= r_b_base + ADDR_W'(r_j)
                                  + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data lands one cycle after rd_en
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_vld   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_vld   <= (r_state == S_RUN);
            r_first <= (r_state == S_RUN) && (r_k == '0);
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk   (wb_clk_i),
        .reset (wb_rst_i),
        .valid (r_vld),
        .first (r_first),
        .a     (rda_data),
        .b     (rdb_data),
        .acc   (w_acc)
    );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer.
// Expected values are hand-computed constants.
module tb_matmul_sequencer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic [31:0] cfg_op   = '0;
    logic [4:0]  cfg_w_a  = '0;
    logic [4:0]  cfg_h_a  = '0;
    logic [4:0]  cfg_w_b  = '0;
    logic [4:0]  cfg_h_b  = '0;
    logic        go       = 1'b0;
    logic [8:0]  rda_addr;
    logic [8:0]  rdb_addr;
    logic        rd_en;
    logic [31:0] rda_data = '0;
    logic [31:0] rdb_data = '0;
    logic        c_we;
    logic [7:0]  c_addr;
    logic [31:0] c_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:511];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] rdb_q [$];
    int rd_cnt;
    int done_cnt;
    int done_cyc;
    logic busy1;
    logic err1;

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        if (rd_en) begin
            rda_data <= mem[rda_addr];
            rdb_data <= mem[rdb_addr];
        end
    end

    matmul_sequencer dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cfg_op   (cfg_op),
        .cfg_w_a  (cfg_w_a),
        .cfg_h_a  (cfg_h_a),
        .cfg_w_b  (cfg_w_b),
        .cfg_h_b  (cfg_h_b),
        .go       (go),
        .rda_addr (rda_addr),
        .rdb_addr (rdb_addr),
        .rd_en    (rd_en),
        .rda_data (rda_data),
        .rdb_data (rdb_data),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(
        input logic [31:0] q [$],
        input int          i
    );
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // go_last: go is held high through that cycle number
    task automatic run_job(
        input int          m,
        input int          k,
        input int          n,
        input int          hb,
        input logic [31:0] op,
        input int          go_last,
        input int          ncyc
    );
        cfg_op  = op;
        cfg_h_a = 5'(m);
        cfg_w_a = 5'(k);
        cfg_w_b = 5'(n);
        cfg_h_b = 5'(hb);
        wr_addr.delete();
        wr_data.delete();
        rdb_q.delete();
        rd_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
        busy1    = 1'b0;
        err1     = 1'b0;
        @(negedge wb_clk_i);
        go = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge wb_clk_i);
            if (c == 1) begin
                busy1 = busy;
                err1  = err;
            end
            if (c_we) begin
                wr_addr.push_back(32'(c_addr));
                wr_data.push_back(c_data);
            end
            if (rd_en) begin
                rd_cnt++;
                rdb_q.push_back(32'(rdb_addr));
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            go = (c <= go_last) ? 1'b1 : 1'b0;
        end
        go = 1'b0;
    endtask

    task automatic load_2x2();
        mem[0] = -3;
        mem[1] = -15;
        mem[2] = -6;
        mem[3] = 7;
        mem[4] = 9;
        mem[5] = -15;
        mem[6] = -2;
        mem[7] = -5;
    endtask

    task automatic check_2x2(input string p);
        chk({p, "_nwr"}, 32'(wr_data.size()), 32'd4);
        chk({p, "_a0"}, qget(wr_addr, 0), 32'd0);
        chk({p, "_a3"}, qget(wr_addr, 3), 32'd3);
        chk({p, "_c0"}, qget(wr_data, 0), 32'd3);
        chk({p, "_c1"}, qget(wr_data, 1), 32'd120);
        chk({p, "_c2"}, qget(wr_data, 2), -68);
        chk({p, "_c3"}, qget(wr_data, 3), 32'd55);
        chk({p, "_done_cyc"}, 32'(done_cyc), 32'd18);
        chk({p, "_done_n"}, 32'(done_cnt), 32'd1);
        chk({p, "_busy1"}, 32'(busy1), 32'd1);
        chk({p, "_busy_end"}, 32'(busy), 32'd0);
        chk({p, "_rd_n"}, 32'(rd_cnt), 32'd8);
    endtask

    initial begin
        int cnt_we;
        int cnt_busy;
        for (int a = 0; a < 512; a++) mem[a] = '0;

        repeat (3) @(negedge wb_clk_i);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_c_we", 32'(c_we), 32'd0);
        chk("rst_rda", 32'(rda_addr), 32'd0);
        chk("rst_rdb", 32'(rdb_addr), 32'd0);
        chk("rst_c_addr", 32'(c_addr), 32'd0);
        chk("rst_c_data", c_data, 32'd0);
        wb_rst_i = 1'b1;

        load_2x2();
        run_job(2, 2, 2, 2, 32'd1, 0, 26);
        check_2x2("sq");

        for (int a = 0; a < 6; a++) mem[a] = 32'(a + 1);
        for (int a = 6; a < 9; a++) mem[a] = 32'd1;
        run_job(2, 3, 1, 3, 32'd1, 0, 18);
        chk("ns_nwr", 32'(wr_data.size()), 32'd2);
        chk("ns_c0", qget(wr_data, 0), 32'd6);
        chk("ns_c1", qget(wr_data, 1), 32'd15);
        chk("ns_a1", qget(wr_addr, 1), 32'd1);
        for (int r = 0; r < 6; r++) begin
            chk("ns_rdb", qget(rdb_q, r), 32'(6 + r % 3));
        end
        chk("ns_done_cyc", 32'(done_cyc), 32'd12);

        run_job(2, 2, 2, 3, 32'd1, 0, 10);
        chk("e1_err", 32'(err), 32'd1);
        chk("e1_rd", 32'(rd_cnt), 32'd0);
        chk("e1_we", 32'(wr_data.size()), 32'd0);
        chk("e1_done", 32'(done_cnt), 32'd0);
        chk("e1_busy", 32'(busy), 32'd0);

        run_job(2, 2, 2, 2, 32'd2, 0, 10);
        chk("e2_err", 32'(err), 32'd1);
        chk("e2_rd", 32'(rd_cnt), 32'd0);
        chk("e2_we", 32'(wr_data.size()), 32'd0);
        chk("e2_done", 32'(done_cnt), 32'd0);

        mem[0] = 32'h7FFF_FFFF;
        mem[1] = 32'd2;
        run_job(1, 1, 1, 1, 32'd1, 0, 10);
        chk("ov_err1", 32'(err1), 32'd0);
        chk("ov_err", 32'(err), 32'd0);
        chk("ov_nwr", 32'(wr_data.size()), 32'd1);
        chk("ov_c0", qget(wr_data, 0), 32'hFFFF_FFFE);
        chk("ov_done_cyc", 32'(done_cyc), 32'd5);

        cfg_op  = 32'd1;
        cfg_h_a = 5'd16;
        cfg_w_a = 5'd16;
        cfg_w_b = 5'd16;
        cfg_h_b = 5'd16;
        @(negedge wb_clk_i);
        go = 1'b1;
        @(negedge wb_clk_i);
        go = 1'b0;
        repeat (10) @(negedge wb_clk_i);
        chk("mr_rd_pre", 32'(rd_en), 32'd1);
        wb_rst_i = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rd_en", 32'(rd_en), 32'd0);
        chk("mr_c_we", 32'(c_we), 32'd0);
        chk("mr_c_data", c_data, 32'd0);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        cnt_we   = 0;
        cnt_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge wb_clk_i);
            if (c_we) cnt_we++;
            if (busy) cnt_busy++;
        end
        chk("mr_idle_we", 32'(cnt_we), 32'd0);
        chk("mr_idle_busy", 32'(cnt_busy), 32'd0);

        load_2x2();
        run_job(2, 2, 2, 2, 32'd1, 0, 26);
        check_2x2("rr");

        run_job(2, 2, 2, 2, 32'd1, 18, 30);
        check_2x2("gg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
